// File: rtl/wb_axis_pkg.sv
// Shared register offsets, STATUS bit positions and Wishbone FSM states for
// the Wishbone-to-AXI-Stream FIFO bridge.
package wb_axis_pkg;

  localparam logic [3:0] OFF_DATA_IN  = 4'h0;
  localparam logic [3:0] OFF_DATA_OUT = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h8;
  localparam logic [3:0] OFF_LEN      = 4'hC;

  localparam int ST_TX_COUNT_LSB = 0;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_RX_EMPTY     = 17;
  localparam int ST_RX_TLAST     = 18;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_axis_fifo_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is read from the
// array combinationally so the stream side sees data with no extra latency.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/wb_axis_fifo_bridge.sv
// Wishbone slave to AXI-Stream bridge: TX FIFO feeds ss_*, RX FIFO collects sm_*.
// Define WB_AXIS_TLAST_EN to add the LEN register and ss_tlast frame generation.
module wb_axis_fifo_bridge
  import wb_axis_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wb_ready,
  output logic          ss_tvalid,
  output logic [DW-1:0] ss_tdata,
  output logic          ss_tlast,
  input  logic          ss_tready,
  input  logic          sm_tvalid,
  input  logic [DW-1:0] sm_tdata,
  input  logic          sm_tlast,
  output logic          sm_tready
);

  wb_state_t     r_state;
  logic          r_ack;
  logic [DW-1:0] r_rdata;

  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic [DW-1:0] w_tx_head;
  logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic [DW:0]   w_rx_head;

  logic          w_is_din, w_is_dout, w_blocked, w_accept;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rd_data;

  assign w_is_din  = (wbs_adr_i == OFF_DATA_IN);
  assign w_is_dout = (wbs_adr_i == OFF_DATA_OUT);

  // A blocked access simply waits with wb_valid held; it is never acked early.
  assign w_blocked = (wbs_we_i & w_is_din & w_tx_full) |
                     (~wbs_we_i & w_is_dout & w_rx_empty);
  assign w_accept  = (r_state == S_IDLE) & wb_valid & ~w_blocked;

  assign w_tx_push = w_accept & wbs_we_i & w_is_din;
  assign w_tx_pop  = ~w_tx_empty & ss_tready;
  assign w_rx_pop  = w_accept & ~wbs_we_i & w_is_dout;
  assign w_rx_push = sm_tvalid & ~w_rx_full;

  assign ss_tvalid = ~w_tx_empty;
  assign ss_tdata  = w_tx_head;
  assign sm_tready = ~w_rx_full;
  assign wb_ready  = r_ack;
  assign wbs_dat_o = r_rdata;

  sync_fifo #(.W(DW), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_tx_push), .i_push_data(wbs_dat_i), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_count(w_tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  sync_fifo #(.W(DW + 1), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_rx_push), .i_push_data({sm_tlast, sm_tdata}), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_count(w_rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // Head tlast is only meaningful when the RX FIFO holds something.
  assign w_status = DW'({13'd0, w_rx_head[DW] & ~w_rx_empty, w_rx_empty, w_tx_full,
                         8'(w_rx_count), 8'(w_tx_count)});

`ifdef WB_AXIS_TLAST_EN
  logic [15:0] r_len;
  logic [15:0] r_beat;
  logic        w_len_wr;
  logic        w_beat_last;

  assign w_len_wr    = w_accept & wbs_we_i & (wbs_adr_i == OFF_LEN);
  assign w_beat_last = (r_len != 16'd0) && (r_beat == r_len - 16'd1);
  assign ss_tlast    = ss_tvalid & w_beat_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_beat <= '0;
    end else if (w_len_wr) begin
      r_len  <= wbs_dat_i[15:0];
      r_beat <= '0;
    end else if (w_tx_pop) begin
      r_beat <= w_beat_last ? 16'd0 : r_beat + 16'd1;
    end
  end
`else
  assign ss_tlast = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (wbs_adr_i)
      OFF_DATA_OUT: w_rd_data = w_rx_head[DW-1:0];
      OFF_STATUS:   w_rd_data = w_status;
`ifdef WB_AXIS_TLAST_EN
      OFF_LEN:      w_rd_data = DW'(r_len);
`endif
      default:      w_rd_data = '0;
    endcase
  end

  // Read data only changes on accepted reads, so it holds across writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (!wbs_we_i) r_rdata <= w_rd_data;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_axis_fifo_bridge.sv
// Self-checking bench for wb_axis_fifo_bridge: scoreboard queues for both
// stream directions, one task per scenario.
module tb_wb_axis_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wbs_we_i;
  logic [3:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic        wb_ready;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       tx_q[$];
  beat_t       rx_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          tlast_seen = 0;
  int unsigned tb_len = 0;
  int unsigned tb_beat = 0;

  logic        t_ack, t_rdy, t_tv;
  logic [31:0] t_rd;
  int          t_cyc;
  int          ev_cyc;
  beat_t       e;

  wb_axis_fifo_bridge #(.DW(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wbs_we_i(wbs_we_i), .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wb_ready(wb_ready),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only at posedge+1, so at negedge the handshake is settled.
  always @(negedge clk) begin
    if (!rst && ss_tvalid && ss_tready) begin
      beat_t x;
      tests_run++;
      if (ss_tlast) tlast_seen++;
      if (tx_q.size() == 0) begin
        tests_failed++;
        $display("FAIL ss_beat_unexpected: got data=%h last=%0d required no beat", ss_tdata, ss_tlast);
      end else begin
        x = tx_q.pop_front();
        if (ss_tdata !== x.data || ss_tlast !== x.last) begin
          tests_failed++;
          $display("FAIL ss_beat: got data=%h last=%0d required data=%h last=%0d",
                   ss_tdata, ss_tlast, x.data, x.last);
        end else
          $display("[TB] ss beat data=%h last=%0d", ss_tdata, ss_tlast);
      end
    end
  end

  task automatic exp_tx(input logic [31:0] d);
    beat_t b;
    b.data = d;
    b.last = (tb_len != 0) && (tb_beat == tb_len - 1);
    if (tb_len != 0) tb_beat = b.last ? 0 : tb_beat + 1;
    tx_q.push_back(b);
  endtask

  task automatic wb_access(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                           input int budget, output logic acked, output logic [31:0] rdata,
                           output int ack_cyc, output logic ready_after, output logic tv_at_ack);
    @(posedge clk); #1;
    wb_valid = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
    acked = 1'b0; rdata = '0; ack_cyc = -1; tv_at_ack = 1'b0;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (wb_ready) begin
        acked = 1'b1; rdata = wbs_dat_o; ack_cyc = cyc; tv_at_ack = ss_tvalid;
      end
    end
    @(posedge clk); #1;
    wb_valid = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    ready_after = wb_ready;
    $display("[TB] wb we=%0d adr=%h dat=%h acked=%0d rdata=%h", we, adr, dat, acked, rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_valid = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    ss_tready = 0; sm_tvalid = 0; sm_tdata = 0; sm_tlast = 0;
    repeat (3) @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run += 5;
    if (wb_ready !== 1'b0)   begin tests_failed++; $display("FAIL rst_wb_ready: got %0d required 0", wb_ready); end
    if (wbs_dat_o !== 32'h0) begin tests_failed++; $display("FAIL rst_dat_o: got %h required 0", wbs_dat_o); end
    if (ss_tvalid !== 1'b0)  begin tests_failed++; $display("FAIL rst_ss_tvalid: got %0d required 0", ss_tvalid); end
    if (ss_tlast !== 1'b0)   begin tests_failed++; $display("FAIL rst_ss_tlast: got %0d required 0", ss_tlast); end
    if (sm_tready !== 1'b1)  begin tests_failed++; $display("FAIL rst_sm_tready: got %0d required 1", sm_tready); end
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h0002_0000) begin tests_failed++; $display("FAIL rst_status: got %h required 00020000", t_rd); end
  endtask

  task automatic test_tx_stream();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    ss_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_tx(words[i]);
      wb_access(1, 4'h0, words[i], 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      tests_run += 3;
      if (t_ack !== 1'b1) begin tests_failed++; $display("FAIL tx_ack: got %0d required 1", t_ack); end
      if (t_rdy !== 1'b0) begin tests_failed++; $display("FAIL tx_ack_len: got ready=%0d required 0", t_rdy); end
      if (t_tv !== 1'b1)  begin tests_failed++; $display("FAIL tx_tvalid_at_ack: got %0d required 1", t_tv); end
    end
    repeat (4) @(posedge clk);
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run += 2;
    if (t_rd !== 32'h0002_0000) begin tests_failed++; $display("FAIL tx_status_drained: got %h required 00020000", t_rd); end
    if (tx_q.size() != 0) begin tests_failed++; $display("FAIL tx_beats_left: got %0d required 0", tx_q.size()); end
  endtask

  task automatic test_tx_full();
    ss_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_tx(32'h100 + i);
      wb_access(1, 4'h0, 32'h100 + i, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      tests_run++;
      if (t_ack !== 1'b1) begin tests_failed++; $display("FAIL full_fill_ack%0d: got %0d required 1", i, t_ack); end
    end
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h0003_0008) begin tests_failed++; $display("FAIL full_status: got %h required 00030008", t_rd); end
    exp_tx(32'h199);
    fork
      wb_access(1, 4'h0, 32'h199, 40, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      begin
        repeat (5) @(posedge clk); #1;
        ss_tready = 1'b1;
        ev_cyc = cyc + 1;
      end
    join
    tests_run += 2;
    if (t_ack !== 1'b1)       begin tests_failed++; $display("FAIL full_stall_ack: got %0d required 1", t_ack); end
    if (t_cyc != ev_cyc + 1)  begin tests_failed++; $display("FAIL full_stall_timing: got cycle %0d required %0d", t_cyc, ev_cyc + 1); end
    repeat (15) @(posedge clk);
    tests_run++;
    if (tx_q.size() != 0) begin tests_failed++; $display("FAIL full_beats_left: got %0d required 0", tx_q.size()); end
  endtask

  task automatic test_rx_read();
    logic [31:0] stat_exp [3];
    stat_exp[0] = 32'h0000_0200; stat_exp[1] = 32'h0004_0100; stat_exp[2] = 32'h0002_0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sm_tvalid = 1'b1; sm_tdata = 32'hA + i; sm_tlast = (i == 1);
      rx_q.push_back({sm_tlast, sm_tdata});
    end
    @(posedge clk); #1; sm_tvalid = 1'b0; sm_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      tests_run++;
      if (t_rd !== stat_exp[i]) begin tests_failed++; $display("FAIL rx_status%0d: got %h required %h", i, t_rd, stat_exp[i]); end
      if (i == 2) break;
      wb_access(0, 4'h4, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      e = rx_q.pop_front();
      tests_run++;
      if (t_rd !== e.data) begin tests_failed++; $display("FAIL rx_data%0d: got %h required %h", i, t_rd, e.data); end
    end
    // A write to DATA_OUT is acked but must leave the last read data in place.
    wb_access(1, 4'h4, 32'hFFFF, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run += 2;
    if (t_ack !== 1'b1) begin tests_failed++; $display("FAIL rx_dout_write_ack: got %0d required 1", t_ack); end
    if (wbs_dat_o !== 32'h0002_0000) begin tests_failed++; $display("FAIL rx_dat_hold: got %h required 00020000", wbs_dat_o); end
  endtask

  task automatic test_rx_stall();
    fork
      wb_access(0, 4'h4, 0, 30, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      begin
        repeat (4) @(posedge clk); #1;
        sm_tvalid = 1'b1; sm_tdata = 32'h5; sm_tlast = 1'b0;
        rx_q.push_back({1'b0, 32'h5});
        ev_cyc = cyc + 1;
        @(posedge clk); #1; sm_tvalid = 1'b0;
      end
    join
    e = rx_q.pop_front();
    tests_run += 3;
    if (t_ack !== 1'b1)      begin tests_failed++; $display("FAIL stall_read_ack: got %0d required 1", t_ack); end
    if (t_cyc != ev_cyc + 1) begin tests_failed++; $display("FAIL stall_read_timing: got cycle %0d required %0d", t_cyc, ev_cyc + 1); end
    if (t_rd !== e.data)     begin tests_failed++; $display("FAIL stall_read_data: got %h required %h", t_rd, e.data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sm_tvalid = 1'b1; sm_tdata = 32'h200 + i; sm_tlast = i[0];
      rx_q.push_back({sm_tlast, sm_tdata});
      @(negedge clk);
      tests_run++;
      if (sm_tready !== 1'b1) begin tests_failed++; $display("FAIL b2b_tready%0d: got %0d required 1", i, sm_tready); end
    end
    @(posedge clk); #1; sm_tdata = 32'hDEAD;
    @(negedge clk);
    tests_run++;
    if (sm_tready !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_tready: got %0d required 0", sm_tready); end
    @(posedge clk); #1; sm_tvalid = 1'b0; sm_tlast = 1'b0;
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h0000_0800) begin tests_failed++; $display("FAIL b2b_status: got %h required 00000800", t_rd); end
    for (int i = 0; i < 8; i++) begin
      wb_access(0, 4'h4, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      e = rx_q.pop_front();
      tests_run++;
      if (t_rd !== e.data) begin tests_failed++; $display("FAIL b2b_data%0d: got %h required %h", i, t_rd, e.data); end
    end
  endtask

  task automatic test_config();
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    wb_access(0, 4'h0, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h0) begin tests_failed++; $display("FAIL din_read: got %h required 0", t_rd); end
`ifdef WB_AXIS_TLAST_EN
    wb_access(1, 4'hC, 32'h4, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tb_len = 4; tb_beat = 0;
    wb_access(0, 4'hC, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h4) begin tests_failed++; $display("FAIL len_readback: got %h required 4", t_rd); end
    tlast_seen = 0;
    ss_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_tx(32'h300 + i);
      wb_access(1, 4'h0, 32'h300 + i, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    end
    repeat (4) @(posedge clk);
    tests_run++;
    if (tlast_seen != 2) begin tests_failed++; $display("FAIL tlast_count: got %0d required 2", tlast_seen); end
`else
    wb_access(1, 4'hC, 32'h4, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    wb_access(0, 4'hC, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run += 2;
    if (t_ack !== 1'b1) begin tests_failed++; $display("FAIL unmapped_ack: got %0d required 1", t_ack); end
    if (t_rd !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read: got %h required 0", t_rd); end
`endif
  endtask

  task automatic test_reset_mid();
    ss_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_tx(32'h400 + i);
      wb_access(1, 4'h0, 32'h400 + i, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    end
    fork
      wb_access(0, 4'h4, 0, 12, t_ack, t_rd, t_cyc, t_rdy, t_tv);
      begin
        repeat (3) @(posedge clk); #1;
        rst = 1'b1; tx_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    tests_run++;
    if (t_ack !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_ack: got %0d required 0", t_ack); end
    wb_access(0, 4'h8, 0, 10, t_ack, t_rd, t_cyc, t_rdy, t_tv);
    tests_run++;
    if (t_rd !== 32'h0002_0000) begin tests_failed++; $display("FAIL rstmid_status: got %h required 00020000", t_rd); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_full();
    test_rx_read();
    test_rx_stall();
    test_back_to_back();
    test_config();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
